// File: rtl/prio_encoder_rr.sv
// Registered request serialiser: captures request lines into a pending set and
// issues one index at a time over valid/ready, fixed-priority or round-robin.
module prio_encoder_rr #(
    parameter int WIDTH = 8,
    parameter int IDX_W = 3,
    parameter int MODE  = 0
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [WIDTH-1:0] req_in,
    input  logic             out_ready,
    output logic             out_valid,
    output logic [IDX_W-1:0] out_idx,
    output logic [WIDTH-1:0] pending,
    output logic             drop,
    output logic             busy
);

    typedef enum logic {EMPTY, FULL} state_t;

    state_t           state;
    logic [WIDTH-1:0] pending_q;
    logic [IDX_W-1:0] rr_ptr;

    logic [WIDTH-1:0] cand;
    logic [WIDTH-1:0] rot;
    logic             slot_free;
    logic [IDX_W-1:0] fix_k;
    logic [IDX_W-1:0] rr_off;
    logic [IDX_W:0]   rr_sum;
    logic [IDX_W:0]   nxt_sum;
    logic [IDX_W-1:0] sel_idx;
    logic [IDX_W-1:0] next_ptr;

    // Selection: highest set bit for fixed mode; for round-robin the candidate
    // vector is rotated so rr_ptr lands at bit 0, the lowest set bit is found,
    // and the offset is added back modulo WIDTH using one spare bit of headroom.
    always_comb begin
        cand      = pending_q | req_in;
        slot_free = (state == EMPTY) || out_ready;

        fix_k = '0;
        for (int i = 0; i < WIDTH; i++) begin
            if (cand[i]) fix_k = IDX_W'(i);
        end

        rot    = WIDTH'({cand, cand} >> rr_ptr);
        rr_off = '0;
        for (int i = WIDTH - 1; i >= 0; i--) begin
            if (rot[i]) rr_off = IDX_W'(i);
        end

        rr_sum = {1'b0, rr_ptr} + {1'b0, rr_off};
        if (rr_sum >= (IDX_W+1)'(WIDTH)) rr_sum = rr_sum - (IDX_W+1)'(WIDTH);

        sel_idx  = (MODE == 0) ? fix_k : rr_sum[IDX_W-1:0];
        nxt_sum  = {1'b0, sel_idx} + (IDX_W+1)'(1);
        next_ptr = (nxt_sum == (IDX_W+1)'(WIDTH)) ? '0 : nxt_sum[IDX_W-1:0];
    end

    // Output slot and pending set; while the slot is stalled new requests only
    // merge into pending_q and the presented index stays frozen.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state     <= EMPTY;
            out_idx   <= '0;
            pending_q <= '0;
            drop      <= 1'b0;
            rr_ptr    <= '0;
        end else begin
            drop <= |(req_in & pending_q);
            if (slot_free) begin
                if (|cand) begin
                    state     <= FULL;
                    out_idx   <= sel_idx;
                    pending_q <= cand & ~(WIDTH'(1) << sel_idx);
                    if (MODE == 1) rr_ptr <= next_ptr;
                end else begin
                    state     <= EMPTY;
                    pending_q <= '0;
                end
            end else begin
                pending_q <= cand;
            end
        end
    end

    assign out_valid = (state == FULL);
    assign pending   = pending_q;
    assign busy      = out_valid | (|pending_q);

endmodule

// File: tb/tb_prio_encoder_rr.sv
// Scoreboard bench for prio_encoder_rr: fixed/8, round-robin/8 and round-robin/5
// instances share stimulus and are checked against a queue-based reference model.
module tb_prio_encoder_rr;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic [7:0] req = '0;
    logic       out_ready = 1'b1;

    logic       fix_valid, rr_valid, rr5_valid;
    logic [2:0] fix_idx, rr_idx, rr5_idx;
    logic [7:0] fix_pend, rr_pend;
    logic [4:0] rr5_pend;
    logic       fix_drop, rr_drop, rr5_drop;
    logic       fix_busy, rr_busy, rr5_busy;

    int total = 0;
    int bad   = 0;

    always #5 clk = ~clk;

    prio_encoder_rr #(.WIDTH(8), .IDX_W(3), .MODE(0)) u_fix (
        .clk(clk), .rst(rst), .req_in(req), .out_ready(out_ready),
        .out_valid(fix_valid), .out_idx(fix_idx), .pending(fix_pend),
        .drop(fix_drop), .busy(fix_busy)
    );

    prio_encoder_rr #(.WIDTH(8), .IDX_W(3), .MODE(1)) u_rr (
        .clk(clk), .rst(rst), .req_in(req), .out_ready(out_ready),
        .out_valid(rr_valid), .out_idx(rr_idx), .pending(rr_pend),
        .drop(rr_drop), .busy(rr_busy)
    );

    prio_encoder_rr #(.WIDTH(5), .IDX_W(3), .MODE(1)) u_rr5 (
        .clk(clk), .rst(rst), .req_in(req[4:0]), .out_ready(out_ready),
        .out_valid(rr5_valid), .out_idx(rr5_idx), .pending(rr5_pend),
        .drop(rr5_drop), .busy(rr5_busy)
    );

    logic       dv[3];
    logic [2:0] di[3];
    logic [7:0] dp[3];
    logic       dd[3];
    logic       db[3];

    assign dv[0] = fix_valid;  assign dv[1] = rr_valid;  assign dv[2] = rr5_valid;
    assign di[0] = fix_idx;    assign di[1] = rr_idx;    assign di[2] = rr5_idx;
    assign dp[0] = fix_pend;   assign dp[1] = rr_pend;   assign dp[2] = {3'b000, rr5_pend};
    assign dd[0] = fix_drop;   assign dd[1] = rr_drop;   assign dd[2] = rr5_drop;
    assign db[0] = fix_busy;   assign db[1] = rr_busy;   assign db[2] = rr5_busy;

    // Reference model: a set of pending request numbers, an output slot and a
    // rotating start position, one entry per instance.
    int  mwid[3]  = '{8, 8, 5};
    int  mmode[3] = '{0, 1, 1};
    bit  mpend[3][8];
    bit  mvalid[3];
    int  mptr[3];
    bit  mdrop[3];
    int  expq[3][$];

    task automatic checkOutput(input string name, input logic [31:0] actual,
                               input logic [31:0] expected);
        total++;
        if (actual !== expected) begin
            bad++;
            $display("[TB] FAIL %s: got %0d expected %0d at %0t", name, actual, expected, $time);
        end
    endtask

    task automatic modelReset();
        for (int n = 0; n < 3; n++) begin
            for (int i = 0; i < 8; i++) mpend[n][i] = 1'b0;
            mvalid[n] = 1'b0;
            mptr[n]   = 0;
            mdrop[n]  = 1'b0;
            expq[n].delete();
        end
    endtask

    function automatic logic [7:0] modelPend(input int n);
        logic [7:0] v;
        v = '0;
        for (int i = 0; i < 8; i++) v[i] = mpend[n][i];
        return v;
    endfunction

    task automatic modelStep(input logic [7:0] r, input logic rdy);
        for (int n = 0; n < 3; n++) begin
            bit cand[8];
            int k;
            int w;
            w = mwid[n];
            mdrop[n] = 1'b0;
            for (int i = 0; i < 8; i++) begin
                cand[i] = 1'b0;
                if (i < w) begin
                    if (r[i] && mpend[n][i]) mdrop[n] = 1'b1;
                    cand[i] = mpend[n][i] | r[i];
                end
            end
            if (!mvalid[n] || rdy) begin
                k = -1;
                if (mmode[n] == 0) begin
                    for (int i = w - 1; i >= 0; i--)
                        if (k < 0 && cand[i]) k = i;
                end else begin
                    for (int s = 0; s < w; s++)
                        if (k < 0 && cand[(mptr[n] + s) % w]) k = (mptr[n] + s) % w;
                end
                if (k >= 0) begin
                    cand[k]   = 1'b0;
                    mvalid[n] = 1'b1;
                    mptr[n]   = (k + 1) % w;
                    expq[n].push_back(k);
                end else begin
                    mvalid[n] = 1'b0;
                end
            end
            for (int i = 0; i < 8; i++) mpend[n][i] = cand[i];
        end
    endtask

    // Drive one cycle of inputs, advance the model on the edge the DUT samples.
    task automatic applyStimulus(input logic [7:0] r, input logic rdy);
        req       = r;
        out_ready = rdy;
        @(posedge clk);
        modelStep(r, rdy);
        #1;
    endtask

    task automatic applyReset();
        req = '0;
        rst = 1'b1;
        modelReset();
        @(posedge clk);
        #1;
        rst = 1'b0;
    endtask

    // Monitor: per-cycle state against the model, issued indices against the queue.
    always @(negedge clk) begin
        if (!rst) begin
            for (int n = 0; n < 3; n++) begin
                checkOutput($sformatf("valid[%0d]", n), 32'(dv[n]), 32'(mvalid[n]));
                checkOutput($sformatf("pending[%0d]", n), 32'(dp[n]), 32'(modelPend(n)));
                checkOutput($sformatf("drop[%0d]", n), 32'(dd[n]), 32'(mdrop[n]));
                checkOutput($sformatf("busy[%0d]", n), 32'(db[n]),
                            32'(mvalid[n] | (|modelPend(n))));
                if (dv[n]) begin
                    if (expq[n].size() == 0) begin
                        total++;
                        bad++;
                        $display("[TB] FAIL issue[%0d]: got idx %0d expected no output", n, di[n]);
                    end else if (out_ready) begin
                        checkOutput($sformatf("issue[%0d]", n), 32'(di[n]), 32'(expq[n].pop_front()));
                    end else begin
                        checkOutput($sformatf("hold[%0d]", n), 32'(di[n]), 32'(expq[n][0]));
                    end
                end
            end
        end
    end

    initial begin
        #200000;
        $display("[TB] FAIL watchdog: got timeout expected finish");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        modelReset();
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0;
        checkOutput("rst_valid", 32'(fix_valid), 0);
        checkOutput("rst_idx", 32'(fix_idx), 0);
        checkOutput("rst_pend", 32'(fix_pend), 0);
        checkOutput("rst_busy", 32'(fix_busy), 0);
        checkOutput("rst_drop", 32'(fix_drop), 0);

        // Fixed priority single requests.
        applyStimulus(8'h80, 1'b1);
        checkOutput("t2_valid", 32'(fix_valid), 1);
        checkOutput("t2_idx7", 32'(fix_idx), 7);
        applyStimulus(8'h00, 1'b1);
        checkOutput("t2_idle", 32'(fix_valid), 0);
        applyStimulus(8'h02, 1'b1);
        checkOutput("t2_idx1", 32'(fix_idx), 1);
        applyStimulus(8'h00, 1'b1);

        // Backpressure holds the slot while the remaining request waits.
        applyStimulus(8'h82, 1'b0);
        checkOutput("t3_idx7", 32'(fix_idx), 7);
        checkOutput("t3_pend", 32'(fix_pend), 32'h02);
        repeat (2) begin
            applyStimulus(8'h00, 1'b0);
            checkOutput("t3_hold", 32'(fix_idx), 7);
            checkOutput("t3_busy", 32'(fix_busy), 1);
        end
        applyStimulus(8'h00, 1'b1);
        checkOutput("t3_idx1", 32'(fix_idx), 1);
        applyStimulus(8'h00, 1'b1);
        checkOutput("t3_idle", 32'(fix_valid), 0);
        checkOutput("t3_nbusy", 32'(fix_busy), 0);

        // Round-robin ordering from a freshly reset pointer.
        applyReset();
        repeat (2) begin
            applyStimulus(8'h83, 1'b1);
            checkOutput("t4_rr0", 32'(rr_idx), 0);
            applyStimulus(8'h00, 1'b1);
            checkOutput("t4_rr1", 32'(rr_idx), 1);
            applyStimulus(8'h00, 1'b1);
            checkOutput("t4_rr7", 32'(rr_idx), 7);
            applyStimulus(8'h00, 1'b1);
            checkOutput("t4_idle", 32'(rr_valid), 0);
        end
        applyStimulus(8'h02, 1'b1);
        checkOutput("t4_one", 32'(rr_idx), 1);
        applyStimulus(8'h00, 1'b1);
        applyStimulus(8'h06, 1'b1);
        checkOutput("t4_ptr2", 32'(rr_idx), 2);
        applyStimulus(8'h00, 1'b1);
        checkOutput("t4_then1", 32'(rr_idx), 1);
        repeat (2) applyStimulus(8'h00, 1'b1);

        // Re-requesting a pending bit pulses drop.
        applyStimulus(8'h06, 1'b0);
        checkOutput("t5_idx2", 32'(fix_idx), 2);
        checkOutput("t5_pend1", 32'(fix_pend), 32'h02);
        checkOutput("t5_nodrop", 32'(fix_drop), 0);
        applyStimulus(8'h06, 1'b0);
        checkOutput("t5_drop", 32'(fix_drop), 1);
        checkOutput("t5_pend2", 32'(fix_pend), 32'h06);
        applyStimulus(8'h00, 1'b1);
        checkOutput("t5_dropend", 32'(fix_drop), 0);
        repeat (4) applyStimulus(8'h00, 1'b1);

        // Non-power-of-two width wraps from 4 back to 0.
        applyReset();
        for (int c = 0; c < 4; c++) begin
            applyStimulus(8'h11, 1'b1);
            checkOutput("t6_rr5", 32'(rr5_idx), (c % 2 == 0) ? 0 : 4);
        end
        repeat (3) applyStimulus(8'h00, 1'b1);

        for (int c = 0; c < 400; c++)
            applyStimulus(8'($urandom & $urandom), ($urandom_range(0, 3) != 0));
        repeat (20) applyStimulus(8'h00, 1'b1);
        for (int n = 0; n < 3; n++)
            checkOutput($sformatf("drained[%0d]", n), 32'(expq[n].size()), 0);

        // Asynchronous reset mid-cycle with a full slot and pending requests.
        applyStimulus(8'h8F, 1'b0);
        checkOutput("t1_pend", 32'(fix_pend), 32'h0F);
        checkOutput("t1_valid", 32'(fix_valid), 1);
        #2;
        rst = 1'b1;
        req = '0;
        modelReset();
        #1;
        checkOutput("t1_valid0", 32'(fix_valid), 0);
        checkOutput("t1_idx0", 32'(fix_idx), 0);
        checkOutput("t1_pend0", 32'(fix_pend), 0);
        checkOutput("t1_drop0", 32'(fix_drop), 0);
        checkOutput("t1_busy0", 32'(fix_busy), 0);
        checkOutput("t1_rrbusy0", 32'(rr_busy), 0);
        @(posedge clk);
        #1;
        rst = 1'b0;
        out_ready = 1'b1;
        repeat (3) applyStimulus(8'h00, 1'b1);
        checkOutput("t1_quiet", 32'(fix_valid), 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
